// File: rtl/acc_drv.sv
// rtl/acc_drv.sv - sequencer that clears an external acc, streams i_len operands into it, and returns the sum
// Operands pass straight through to the accumulator; the result is captured one cycle after the last beat.
module acc_drv #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_busy,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_acc,
   output logic [WIDTH-1:0] o_acc_data,
   output logic             o_acc_clr,
   input  logic [WIDTH-1:0] i_acc_sum,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // FRAC only describes the fixed-point format of the stream; values are never rescaled here.
   if (FRAC > WIDTH) begin : g_frac_wider_than_word
   end

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_data;
   logic             w_beat;

   assign o_busy     = (r_state != S_IDLE);
   assign o_ready    = (r_state == S_RUN);
   assign w_beat     = i_valid & o_ready;
   assign o_acc      = w_beat;
   assign o_acc_data = w_beat ? i_data : '0;
   assign o_acc_clr  = (r_state == S_CLR);
   assign o_valid    = (r_state == S_DONE);
   assign o_data     = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_count <= i_len;
                  r_state <= S_CLR;
               end
            end
            S_CLR: begin
               r_state <= (r_count != '0) ? S_RUN : S_WAIT;
            end
            S_RUN: begin
               if (w_beat) begin
                  r_count <= r_count - 1'b1;
                  if (r_count == CNT_W'(1))
                     r_state <= S_WAIT;
               end
            end
            // The accumulator registered the last term on the previous edge, so its output is final now.
            S_WAIT: begin
               r_data  <= i_acc_sum;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (i_ready)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_drv.sv
// tb/tb_acc_drv.sv - directed self-checking bench for acc_drv with a behavioural accumulator
// Inputs change and outputs are sampled on the falling clock edge.
module tb_acc_drv;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [7:0]  i_len;
   logic        o_busy;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_data;
   logic        o_acc;
   logic [31:0] o_acc_data;
   logic        o_acc_clr;
   logic [31:0] i_acc_sum;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;

   logic [31:0] r_acc = 32'h0;
   logic        stale_load = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   acc_drv #(.WIDTH(32), .FRAC(24), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_len      (i_len),
      .o_busy     (o_busy),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data     (i_data),
      .o_acc      (o_acc),
      .o_acc_data (o_acc_data),
      .o_acc_clr  (o_acc_clr),
      .i_acc_sum  (i_acc_sum),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data     (o_data)
   );

   // Accumulator model: clear has priority, otherwise add on o_acc.
   always @(posedge clk) begin
      if (stale_load)
         r_acc <= 32'h12345678;
      else if (o_acc_clr)
         r_acc <= 32'h0;
      else if (o_acc)
         r_acc <= r_acc + o_acc_data;
   end
   assign i_acc_sum = r_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic start_sum(input logic [7:0] len);
      i_start = 1'b1;
      i_len   = len;
      @(negedge clk);
      i_start = 1'b0;
      #1;
      chk("clr_pulse", {31'b0, o_acc_clr}, 32'd1);
      chk("clr_busy", {31'b0, o_busy}, 32'd1);
      chk("clr_ready", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("clr_single", {31'b0, o_acc_clr}, 32'd0);
      chk("ready_after_clr", {31'b0, o_ready}, {31'b0, (len != 8'd0)});
   endtask

   task automatic feed(input logic [31:0] d, input int gap);
      for (int g = 0; g < gap; g++) begin
         i_valid = 1'b0;
         i_data  = 32'hDEADBEEF;
         #1;
         chk("gap_acc", {31'b0, o_acc}, 32'd0);
         chk("gap_acc_data", o_acc_data, 32'd0);
         @(negedge clk);
      end
      i_valid = 1'b1;
      i_data  = d;
      #1;
      chk("beat_acc", {31'b0, o_acc}, 32'd1);
      chk("beat_data", o_acc_data, d);
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   // Called in the WAIT cycle; o_valid must rise exactly one cycle later.
   task automatic get_result(input logic [31:0] exp);
      #1;
      chk("wait_valid", {31'b0, o_valid}, 32'd0);
      chk("wait_ready", {31'b0, o_ready}, 32'd0);
      chk("wait_acc", {31'b0, o_acc}, 32'd0);
      @(negedge clk);
      #1;
      chk("done_valid", {31'b0, o_valid}, 32'd1);
      chk("done_data", o_data, exp);
      chk("done_ready", {31'b0, o_ready}, 32'd0);
   endtask

   task automatic accept_result();
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      #1;
      chk("idle_valid", {31'b0, o_valid}, 32'd0);
      chk("idle_busy", {31'b0, o_busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1; i_start = 1'b0; i_len = 8'd0; i_valid = 1'b0;
      i_data = 32'h0; i_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      chk("rst_ready", {31'b0, o_ready}, 32'd0);
      chk("rst_acc", {31'b0, o_acc}, 32'd0);
      chk("rst_acc_data", o_acc_data, 32'd0);
      chk("rst_clr", {31'b0, o_acc_clr}, 32'd0);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_data", o_data, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1) four terms, back to back
      start_sum(8'd4);
      feed(32'h01000000, 0);
      feed(32'h02000000, 0);
      feed(32'h03000000, 0);
      feed(32'h04000000, 0);
      get_result(32'h0A000000);
      accept_result();

      // 2) three terms with two-cycle gaps, mixed signs
      start_sum(8'd3);
      feed(32'h02000000, 0);
      feed(32'hFF000000, 2);
      feed(32'hFF800000, 2);
      get_result(32'h00800000);
      accept_result();

      // 3) zero terms with a stale accumulator
      stale_load = 1'b1;
      @(negedge clk);
      stale_load = 1'b0;
      chk("stale_loaded", i_acc_sum, 32'h12345678);
      start_sum(8'd0);
      get_result(32'h0);
      accept_result();

      // 4) result held while i_ready is low; i_start ignored
      start_sum(8'd1);
      feed(32'h00400000, 0);
      get_result(32'h00400000);
      held = o_data;
      for (int k = 0; k < 5; k++) begin
         i_start = 1'b1;
         i_len   = 8'd7;
         @(negedge clk);
         #1;
         chk("hold_valid", {31'b0, o_valid}, 32'd1);
         chk("hold_data", o_data, held);
         chk("hold_noclr", {31'b0, o_acc_clr}, 32'd0);
      end
      i_start = 1'b0;
      accept_result();
      @(negedge clk);
      #1;
      chk("no_relatch", {31'b0, o_busy}, 32'd0);
      chk("data_kept", o_data, 32'h00400000);

      // 5) i_start during RUN does not extend the sum
      start_sum(8'd3);
      i_start = 1'b1;
      i_len   = 8'd5;
      feed(32'h01000000, 0);
      i_start = 1'b1;
      feed(32'h00800000, 0);
      feed(32'h00400000, 0);
      i_start = 1'b0;
      i_valid = 1'b1;
      i_data  = 32'h07000000;
      get_result(32'h01C00000);
      i_valid = 1'b0;
      accept_result();

      // wraparound: no saturation
      start_sum(8'd2);
      feed(32'h7FFFFFFF, 0);
      feed(32'h00000001, 0);
      get_result(32'h80000000);
      accept_result();

      // 6) reset mid-run, then a clean run
      start_sum(8'd4);
      feed(32'h03000000, 0);
      feed(32'h03000000, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'b0, o_busy}, 32'd0);
      chk("abort_ready", {31'b0, o_ready}, 32'd0);
      chk("abort_valid", {31'b0, o_valid}, 32'd0);
      chk("abort_noclr", {31'b0, o_acc_clr}, 32'd0);
      chk("abort_data", o_data, 32'd0);
      @(negedge clk);
      start_sum(8'd2);
      feed(32'h01000000, 0);
      feed(32'h01000000, 0);
      get_result(32'h02000000);
      accept_result();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
